// File: rtl/par_to_ser_pkg.sv
// Shared types and limits for the parallel-to-serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: transmitter state enum and the maximum supported word width.
package par_to_ser_pkg;

    localparam int PAR_TO_SER_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/par_to_ser.sv
// Parallel-in serial-out transmitter: WIDTH-bit words in over valid/ready, one bit out per i_ce pulse.
// Latency: first bit on o_data one cycle after the accept edge; WIDTH (+1 parity) i_ce pulses per word.
// Backpressure: o_ready only in IDLE or on the final bit with i_ce; a word offered while busy is not taken.
//
// Ports:
//   i_clk, i_reset_n    system clock, synchronous active-low reset
//   i_ce                bit-rate enable, one bit advances per cycle with i_ce=1
//   i_valid/i_word      upstream word, sampled only on accept
//   o_ready             transmitter can accept a word this cycle
//   o_data/o_ce/o_last  serial bit (registered), downstream enable, final bit of frame
//
// Optional feature macro: PAR_TO_SER_PARITY_EN appends an even-parity bit to every word.
module par_to_ser
    import par_to_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ce,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_word,
    output logic             o_ready,
    output logic             o_data,
    output logic             o_ce,
    output logic             o_last
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             data_q;

    logic             accept;
    logic             last_data_bit;
    logic [WIDTH-1:0] shreg_shifted;
    logic             next_head;
    logic             first_head;

`ifdef PAR_TO_SER_PARITY_EN
    logic             par_q;
`endif

    // The head of the shift register is always the bit on the wire; o_data
    // registers the head so it is valid the cycle after every load or shift.
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    assign next_head     = (MSB_FIRST != 0) ? shreg[WIDTH-2] : shreg[1];
    assign first_head    = (MSB_FIRST != 0) ? i_word[WIDTH-1] : i_word[0];

    assign last_data_bit = (state == SHIFT) && (cnt == LAST_CNT);

`ifdef PAR_TO_SER_PARITY_EN
    assign o_last = (state == PARITY);
`else
    assign o_last = last_data_bit;
`endif

    assign o_ce    = (state != IDLE) && i_ce;
    // Accepting on the final-bit edge lets the next frame follow with no gap.
    assign o_ready = i_reset_n && ((state == IDLE) || (o_last && i_ce));
    assign accept  = i_valid && o_ready;
    assign o_data  = data_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            data_q <= 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else if (accept) begin
            // Only reachable from IDLE or the final bit, so it can pre-empt the case below.
            state  <= SHIFT;
            shreg  <= i_word;
            cnt    <= '0;
            data_q <= first_head;
`ifdef PAR_TO_SER_PARITY_EN
            par_q  <= ^i_word;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (i_ce) begin
                        if (last_data_bit) begin
                            shreg <= '0;
                            cnt   <= '0;
`ifdef PAR_TO_SER_PARITY_EN
                            state  <= PARITY;
                            data_q <= par_q;
`else
                            state  <= IDLE;
                            data_q <= 1'b0;
`endif
                        end else begin
                            shreg  <= shreg_shifted;
                            cnt    <= cnt + 1'b1;
                            data_q <= next_head;
                        end
                    end
                end
`ifdef PAR_TO_SER_PARITY_EN
                PARITY: begin
                    if (i_ce) begin
                        state  <= IDLE;
                        data_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    data_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FORMAL
    localparam int F_FRAME = WIDTH
`ifdef PAR_TO_SER_PARITY_EN
                             + 1
`endif
                             ;

    // Bits emitted so far in the current frame.
    logic [CNT_W:0] f_bits;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || accept) begin
            f_bits <= '0;
        end else if (o_ce) begin
            f_bits <= f_bits + 1'b1;
        end
    end

    always_comb begin
        assert (WIDTH >= 2 && WIDTH <= PAR_TO_SER_MAX_WIDTH);
        assert (!(o_ce && state == IDLE));
        assert (int'(cnt) < WIDTH);
        assert (!(accept && state != IDLE && !(o_last && i_ce)));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n && o_last && i_ce) begin
            assert (int'(f_bits) + 1 == F_FRAME);
        end
    end
`endif

endmodule

// File: tb/tb_par_to_ser.sv
// Self-checking bench for par_to_ser: scoreboard of expected serial bits per accepted word.
// Two instances (MSB first / LSB first) share clock, reset and bit-rate enable.
// Expected bits, o_last, o_ready and idle/hold behaviour come from a small model in the bench.
module tb_par_to_ser;

    localparam int W = 8;
`ifdef PAR_TO_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         ce     = 1'b1;
    int           ce_div = 1;
    int           cyc    = 0;

    logic         vld_a  = 1'b0;
    logic [W-1:0] word_a = '0;
    logic         rdy_a, dat_a, oce_a, last_a;
    logic         vld_b  = 1'b0;
    logic [W-1:0] word_b = '0;
    logic         rdy_b, dat_b, oce_b, last_b;

    int           n_checks = 0;
    int           n_errors = 0;

    logic [1:0]   exp_a[$];
    logic [1:0]   exp_b[$];
    logic [1:0]   e;
    int           n_ce_a = 0;
    int           n_ce_b = 0;
    int           n_extra = 0;
    int           last_ce_cyc = 0;
    logic         prev_oce = 1'b0;
    logic         prev_acc = 1'b0;
    logic         prev_rst = 1'b0;
    logic         prev_dat = 1'b0;
    logic         rdy_exp;

    par_to_ser #(.WIDTH(W), .MSB_FIRST(1)) u_dut_a (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_ce     (ce),
        .i_valid  (vld_a),
        .i_word   (word_a),
        .o_ready  (rdy_a),
        .o_data   (dat_a),
        .o_ce     (oce_a),
        .o_last   (last_a)
    );

    par_to_ser #(.WIDTH(W), .MSB_FIRST(0)) u_dut_b (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_ce     (ce),
        .i_valid  (vld_b),
        .i_word   (word_b),
        .o_ready  (rdy_b),
        .o_data   (dat_b),
        .o_ce     (oce_b),
        .o_last   (last_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ce = (ce_div <= 1) ? 1'b1 : ((cyc % ce_div) == 0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model of one frame position: {last, bit}.
    function automatic logic [1:0] frame_bit(input logic [W-1:0] w, input int i, input bit msb);
        logic b;
        if (i == W) return {1'b1, ^w};
        b = msb ? w[W-1-i] : w[i];
        return {(i == FRAME - 1), b};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            // Instance A
            rdy_exp = (exp_a.size() == 0) || (exp_a.size() == 1 && ce);
            check_eq("a_ready", rdy_a, rdy_exp);
            if (exp_a.size() == 0 && !oce_a) check_eq("a_idle_data", dat_a, 0);
            if (prev_rst && !prev_oce && !prev_acc) check_eq("a_hold", dat_a, prev_dat);
            if (oce_a) begin
                n_ce_a++;
                last_ce_cyc = cyc;
                if (exp_a.size() == 0) n_extra++;
                else begin
                    e = exp_a.pop_front();
                    check_eq("a_bit", dat_a, e[0]);
                    check_eq("a_last", last_a, e[1]);
                end
            end
            if (vld_a && rdy_a)
                for (int i = 0; i < FRAME; i++) exp_a.push_back(frame_bit(word_a, i, 1'b1));

            // Instance B
            rdy_exp = (exp_b.size() == 0) || (exp_b.size() == 1 && ce);
            check_eq("b_ready", rdy_b, rdy_exp);
            if (exp_b.size() == 0 && !oce_b) check_eq("b_idle_data", dat_b, 0);
            if (oce_b) begin
                n_ce_b++;
                if (exp_b.size() == 0) n_extra++;
                else begin
                    e = exp_b.pop_front();
                    check_eq("b_bit", dat_b, e[0]);
                    check_eq("b_last", last_b, e[1]);
                end
            end
            if (vld_b && rdy_b)
                for (int i = 0; i < FRAME; i++) exp_b.push_back(frame_bit(word_b, i, 1'b0));
        end
        prev_oce = oce_a;
        prev_acc = vld_a && rdy_a;
        prev_rst = rst_n;
        prev_dat = dat_a;
    end

    // Called just after a rising edge; returns with inputs changed just after a rising edge.
    task automatic send(input bit sel, input logic [W-1:0] w, output int acc_cyc);
        bit done = 1'b0;
        acc_cyc = -1;
        if (sel) begin vld_b = 1'b1; word_b = w; end
        else begin vld_a = 1'b1; word_a = w; end
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = sel ? rdy_b : rdy_a;
            if (done) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        if (sel) begin vld_b = 1'b0; word_b = W'($urandom); end
        else begin vld_a = 1'b0; word_a = W'($urandom); end
        check_eq(sel ? "b_accept" : "a_accept", done, 1);
    endtask

    task automatic drain();
        int left = 1;
        for (int k = 0; k < 600 && left != 0; k++) begin
            @(negedge clk);
            #1;
            left = exp_a.size() + exp_b.size();
        end
        check_eq("drain", left, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, t0, t1, tx;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", rdy_a, 0);
        check_eq("rst_data", dat_a, 0);
        check_eq("rst_ce", oce_a, 0);
        check_eq("rst_last", last_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready_a", rdy_a, 1);
        check_eq("rel_ready_b", rdy_b, 1);
        @(posedge clk);
        #1;

        // 0xA5 at full rate
        n0 = n_ce_a;
        send(1'b0, 8'hA5, t0);
        drain();
        check_eq("a5_pulses", n_ce_a - n0, FRAME);

        // 0xA5 with i_ce every third cycle
        ce_div = 3;
        n0 = n_ce_a;
        send(1'b0, 8'hA5, t0);
        drain();
        check_eq("a5_slow_pulses", n_ce_a - n0, FRAME);
        ce_div = 1;

        // Back-to-back 0xA5, 0x3C with valid held
        n0 = n_ce_a;
        send(1'b0, 8'hA5, t0);
        send(1'b0, 8'h3C, t1);
        drain();
        check_eq("b2b_pulses", n_ce_a - n0, 2 * FRAME);
        check_eq("b2b_reload", t1 - t0, FRAME);
        check_eq("b2b_span", last_ce_cyc - t0, 2 * FRAME);

        // LSB first, 0x01
        n0 = n_ce_b;
        send(1'b1, 8'h01, t0);
        drain();
        check_eq("lsb_pulses", n_ce_b - n0, FRAME);

        // Three low bits (parity tail when enabled)
        send(1'b0, 8'h07, t0);
        drain();

        // Reset after three bits of 0xFF
        n0 = n_ce_a;
        send(1'b0, 8'hFF, t0);
        for (int k = 0; k < 100 && (n_ce_a - n0) < 3; k++) begin
            @(negedge clk);
            #1;
        end
        check_eq("rst_mid_bits", n_ce_a - n0, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_mid_data", dat_a, 0);
        check_eq("rst_mid_ce", oce_a, 0);
        check_eq("rst_mid_ready", rdy_a, 0);
        check_eq("rst_mid_last", last_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_rel_ready", rdy_a, 1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("rst_mid_no_more", n_ce_a - n0, 3);

        // Random words, random bit rate, both bit orders
        for (int i = 0; i < 10; i++) begin
            ce_div = $urandom_range(1, 3);
            send(1'(i % 2), W'($urandom), tx);
            if ((i % 3) == 2) drain();
        end
        drain();
        ce_div = 1;

        check_eq("extra_ce", n_extra, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
